// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and memory-stage state encoding.
// MEM_ALIGN_CHECK_EN enables the misaligned-access trap path in mem_stage.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // funct3[1:0] gives access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load lane extraction/extension and store lane/byte-enable generation.
// Halfwords use only off[1]; words ignore the offset entirely.
module mem_lane_align
    import rv_pkg::*;
(
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data,
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata
);

    logic [31:0] w_bsh;
    logic [31:0] w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsh  = i_rdata >> {i_ld_off, 3'b000};
    assign w_hsh  = i_rdata >> {i_ld_off[1], 4'b0000};
    assign w_byte = w_bsh[7:0];
    assign w_half = w_hsh[15:0];

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        case (i_st_funct3[1:0])
            2'b00: begin
                o_st_be    = 4'b0001 << i_st_off;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_st_be    = 4'b0011 << {i_st_off[1], 1'b0};
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: valid/ready pipeline slot with a blocking dmem port.
// `define MEM_ALIGN_CHECK_EN adds the misalign output and trap-to-FULL path.
module mem_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        v_in,
    output logic        r_out,
    input  logic [31:0] IR,
    input  logic [31:0] ALU,
    input  logic [31:0] PC,
    input  logic [31:0] B,
    input  logic        COMP,
    output logic [31:0] IR_out,
    output logic [31:0] WB_out,
    output logic        v_out,
    input  logic        r_in,
    output logic [31:0] FM,
    output logic [4:0]  AM,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    state_t      r_state;
    logic [31:0] r_ir;
    logic [31:0] r_wb;
    logic        r_wr;
    logic        r_br;
    logic [31:0] r_br_target;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        r_mis;
`endif

    logic        w_accept;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_br;
    logic        w_is_jmp;
    logic        w_mis;
    logic        w_issue;
    logic [31:0] w_wb_next;
    logic [31:0] w_ld_data;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;

    assign r_out    = (r_state == ST_IDLE) | ((r_state == ST_FULL) & r_in);
    assign w_accept = v_in & r_out;
    assign w_is_ld  = IR[6:0] == OP_LOAD;
    assign w_is_st  = IR[6:0] == OP_STORE;
    assign w_is_br  = IR[6:0] == OP_BRANCH;
    assign w_is_jmp = (IR[6:0] == OP_JAL) | (IR[6:0] == OP_JALR);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_mis = (w_is_ld | w_is_st) & misaligned(IR[14:12], ALU[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_issue = (w_is_ld | w_is_st) & ~w_mis;

    always_comb begin
        w_wb_next = ALU;
        unique case (1'b1)
            w_is_jmp:                    w_wb_next = PC + 32'd4;
            w_is_ld | w_is_st | w_is_br: w_wb_next = '0;
            default:                     w_wb_next = ALU;
        endcase
    end

    // load side works off the captured access, store side off the new one
    mem_lane_align u_lane (
        .i_ld_funct3 (r_ir[14:12]),
        .i_ld_off    (r_dmem_addr[1:0]),
        .i_rdata     (dmem_rdata),
        .o_ld_data   (w_ld_data),
        .i_st_funct3 (IR[14:12]),
        .i_st_off    (ALU[1:0]),
        .i_st_data   (B),
        .o_st_be     (w_st_be),
        .o_st_wdata  (w_st_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ir         <= '0;
            r_wb         <= '0;
            r_wr         <= 1'b0;
            r_br         <= 1'b0;
            r_br_target  <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_mis        <= 1'b0;
`endif
        end else begin
            r_br <= 1'b0;
            unique case (r_state)
                ST_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= ST_FULL;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_dmem_be  <= '0;
                        if (r_ir[6:0] == OP_LOAD)
                            r_wb <= w_ld_data;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state    <= w_issue ? ST_WAIT : ST_FULL;
                        r_ir       <= IR;
                        r_wb       <= w_wb_next;
                        r_wr       <= ~(w_is_st | w_is_br | w_mis);
                        r_br       <= w_is_br & COMP;
                        r_dmem_req <= w_issue;
                        r_dmem_we  <= w_issue & w_is_st;
                        r_dmem_be  <= (w_issue & w_is_st) ? w_st_be : 4'b0000;
`ifdef MEM_ALIGN_CHECK_EN
                        r_mis      <= w_mis;
`endif
                        if (w_is_br & COMP)
                            r_br_target <= ALU;
                        if (w_issue)
                            r_dmem_addr <= ALU;
                        if (w_issue & w_is_st)
                            r_dmem_wdata <= w_st_wdata;
                    end else if ((r_state == ST_FULL) & r_in) begin
                        r_state <= ST_IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                        r_mis   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign v_out      = r_state == ST_FULL;
    assign IR_out     = r_ir;
    assign WB_out     = r_wb;
    assign FM         = r_wb;
    assign AM         = (v_out & r_wr) ? r_ir[11:7] : 5'd0;
    assign br_taken   = r_br;
    assign br_target  = r_br_target;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_be    = r_dmem_be;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign   = r_mis;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage; expected results go through a queue.
// Inputs change on negedge, outputs are checked on negedge.
module tb_mem_stage;

    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_JR  = 7'b1100111;
    localparam logic [6:0] T_OP  = 7'b0110011;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] wb;
        logic [4:0]  am;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, v_in, r_in, COMP, dmem_ack;
    logic [31:0] IR, ALU, PC, B, dmem_rdata;
    logic        r_out, v_out, br_taken, dmem_req, dmem_we;
    logic [31:0] IR_out, WB_out, FM, br_target, dmem_addr, dmem_wdata;
    logic [4:0]  AM;
    logic [3:0]  dmem_be;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .v_in       (v_in),
        .r_out      (r_out),
        .IR         (IR),
        .ALU        (ALU),
        .PC         (PC),
        .B          (B),
        .COMP       (COMP),
        .IR_out     (IR_out),
        .WB_out     (WB_out),
        .v_out      (v_out),
        .r_in       (r_in),
        .FM         (FM),
        .AM         (AM),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign   (misalign),
`endif
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {12'h000, 5'd1, f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] b,
                         input logic comp);
        v_in = 1'b1; IR = ir; ALU = alu; PC = pc; B = b; COMP = comp;
    endtask

    task automatic test_reset();
        rst = 1'b1; v_in = 1'b0; r_in = 1'b1; COMP = 1'b0; dmem_ack = 1'b0;
        IR = '0; ALU = '0; PC = '0; B = '0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (v_out !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
            br_taken !== 1'b0 || AM !== 5'd0 || dmem_be !== 4'd0 ||
            WB_out !== 32'd0 || IR_out !== 32'd0)
            begin n_fail++; $display("FAIL reset_outs: v=%b req=%b we=%b br=%b AM=%0d be=%b WB=%h IR=%h required all 0",
                v_out, dmem_req, dmem_we, br_taken, AM, dmem_be, WB_out, IR_out); end
        n_tests++;
        if (r_out !== 1'b1) begin n_fail++; $display("FAIL reset_rout: got %b required 1", r_out); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] ir;
        ir = mk(T_OP, 3'b000, 5'd5);
        @(negedge clk);
        drive(ir, 32'h10, 32'h400, 32'h0, 1'b0);
        q.push_back('{ir: ir, wb: 32'h10, am: 5'd5});
        @(negedge clk); v_in = 1'b0;
        n_tests++;
        if (v_out !== 1'b1 || dmem_req !== 1'b0)
            begin n_fail++; $display("FAIL add_lat: v_out=%b req=%b required 1 0", v_out, dmem_req); end
        e = q.pop_front(); n_tests++;
        if (IR_out !== e.ir || WB_out !== e.wb || FM !== e.wb || AM !== e.am)
            begin n_fail++; $display("FAIL add_res: IR=%h WB=%h FM=%h AM=%0d required %h %h %0d", IR_out, WB_out, FM, AM, e.ir, e.wb, e.am); end
        @(negedge clk);
        n_tests++;
        if (v_out !== 1'b0 || AM !== 5'd0)
            begin n_fail++; $display("FAIL add_idle: v_out=%b AM=%0d required 0 0", v_out, AM); end
    endtask

    task automatic test_load();
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] al [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h104};
        logic [31:0] rd [5] = '{32'h80123456, 32'h1234F678, 32'h8001ABCD, 32'h1234ABCD, 32'hDEADBEEF};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h000000F6, 32'hFFFF8001, 32'h0000ABCD, 32'hDEADBEEF};
        logic [31:0] ir;
        for (int i = 0; i < 5; i++) begin
            ir = mk(T_LD, f3[i], 5'(3 + i));
            @(negedge clk);
            drive(ir, al[i], 32'h0, 32'hFFFFFFFF, 1'b0);
            q.push_back('{ir: ir, wb: ex[i], am: 5'(3 + i)});
            @(negedge clk); v_in = 1'b0;
            n_tests++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== al[i] || r_out !== 1'b0 || AM !== 5'd0)
                begin n_fail++; $display("FAIL ld%0d_req: req=%b we=%b addr=%h r_out=%b AM=%0d required 1 0 %h 0 0",
                    i, dmem_req, dmem_we, dmem_addr, r_out, AM, al[i]); end
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); n_tests++;
                if (r_out !== 1'b0 || dmem_req !== 1'b1 || v_out !== 1'b0 || dmem_addr !== al[i])
                    begin n_fail++; $display("FAIL ld%0d_wait: r_out=%b req=%b v_out=%b addr=%h required 0 1 0 %h",
                        i, r_out, dmem_req, v_out, dmem_addr, al[i]); end
            end
            dmem_ack = 1'b1; dmem_rdata = rd[i];
            @(negedge clk); dmem_ack = 1'b0; dmem_rdata = 32'h0;
            n_tests++;
            if (v_out !== 1'b1 || dmem_req !== 1'b0)
                begin n_fail++; $display("FAIL ld%0d_done: v_out=%b req=%b required 1 0", i, v_out, dmem_req); end
            e = q.pop_front(); n_tests++;
            if (IR_out !== e.ir || WB_out !== e.wb || FM !== e.wb || AM !== e.am)
                begin n_fail++; $display("FAIL ld%0d_res: IR=%h WB=%h FM=%h AM=%0d required %h %h %0d",
                    i, IR_out, WB_out, FM, AM, e.ir, e.wb, e.am); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3 [4] = '{3'b001, 3'b000, 3'b000, 3'b010};
        logic [31:0] al [4] = '{32'h102, 32'h101, 32'h103, 32'h100};
        logic [31:0] bv [4] = '{32'h0000BEEF, 32'h000012A5, 32'h0000003C, 32'h12345678};
        logic [3:0]  be [4] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111};
        logic [31:0] wd [4] = '{32'hBEEFBEEF, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'h12345678};
        logic [31:0] ir;
        for (int i = 0; i < 4; i++) begin
            ir = mk(T_ST, f3[i], 5'd9);
            @(negedge clk);
            drive(ir, al[i], 32'h0, bv[i], 1'b0);
            q.push_back('{ir: ir, wb: 32'h0, am: 5'd0});
            @(negedge clk); v_in = 1'b0; B = 32'hFFFFFFFF; ALU = 32'h0;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== be[i] || dmem_wdata !== wd[i] || dmem_addr !== al[i])
                    begin n_fail++; $display("FAIL st%0d_bus%0d: req=%b we=%b be=%b wd=%h addr=%h required 1 1 %b %h %h",
                        i, k, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, be[i], wd[i], al[i]); end
                if (k == 0) @(negedge clk);
            end
            dmem_ack = 1'b1;
            @(negedge clk); dmem_ack = 1'b0;
            e = q.pop_front(); n_tests++;
            if (v_out !== 1'b1 || dmem_we !== 1'b0 || IR_out !== e.ir || WB_out !== e.wb || AM !== e.am)
                begin n_fail++; $display("FAIL st%0d_res: v=%b we=%b IR=%h WB=%h AM=%0d required 1 0 %h %h %0d",
                    i, v_out, dmem_we, IR_out, WB_out, AM, e.ir, e.wb, e.am); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ir;
        ir = mk(T_BR, 3'b000, 5'd7);
        @(negedge clk); r_in = 1'b0;
        drive(ir, 32'h200, 32'h100, 32'h0, 1'b1);
        q.push_back('{ir: ir, wb: 32'h0, am: 5'd0});
        @(negedge clk); v_in = 1'b0; COMP = 1'b0;
        n_tests++;
        if (br_taken !== 1'b1 || br_target !== 32'h200 || v_out !== 1'b1 || dmem_req !== 1'b0)
            begin n_fail++; $display("FAIL beq_take: br=%b tgt=%h v=%b req=%b required 1 00000200 1 0", br_taken, br_target, v_out, dmem_req); end
        e = q.pop_front(); n_tests++;
        if (IR_out !== e.ir || WB_out !== e.wb || AM !== e.am)
            begin n_fail++; $display("FAIL beq_res: IR=%h WB=%h AM=%0d required %h %h %0d", IR_out, WB_out, AM, e.ir, e.wb, e.am); end
        @(negedge clk);
        n_tests++;
        if (br_taken !== 1'b0 || br_target !== 32'h200 || v_out !== 1'b1)
            begin n_fail++; $display("FAIL beq_pulse: br=%b tgt=%h v=%b required 0 00000200 1", br_taken, br_target, v_out); end
        r_in = 1'b1;
        ir = mk(T_BR, 3'b001, 5'd4);
        @(negedge clk);
        drive(ir, 32'h300, 32'h100, 32'h0, 1'b0);
        @(negedge clk); v_in = 1'b0;
        n_tests++;
        if (br_taken !== 1'b0 || br_target !== 32'h200 || AM !== 5'd0)
            begin n_fail++; $display("FAIL bne_nt: br=%b tgt=%h AM=%0d required 0 00000200 0", br_taken, br_target, AM); end
    endtask

    task automatic test_jump();
        logic [6:0]  op [2] = '{T_JAL, T_JR};
        logic [31:0] pc [2] = '{32'h1000, 32'h2000};
        logic [31:0] ir;
        for (int i = 0; i < 2; i++) begin
            ir = mk(op[i], 3'b000, 5'(1 + i));
            @(negedge clk);
            drive(ir, 32'hDEAD0000, pc[i], 32'h0, 1'b0);
            q.push_back('{ir: ir, wb: pc[i] + 32'd4, am: 5'(1 + i)});
            @(negedge clk); v_in = 1'b0;
            e = q.pop_front(); n_tests++;
            if (v_out !== 1'b1 || IR_out !== e.ir || WB_out !== e.wb || AM !== e.am)
                begin n_fail++; $display("FAIL jmp%0d: v=%b IR=%h WB=%h AM=%0d required 1 %h %h %0d",
                    i, v_out, IR_out, WB_out, AM, e.ir, e.wb, e.am); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ir7, ir8;
        ir7 = mk(T_OP, 3'b000, 5'd7);
        ir8 = mk(T_OP, 3'b000, 5'd8);
        @(negedge clk); r_in = 1'b0;
        drive(ir7, 32'h55, 32'h0, 32'h0, 1'b0);
        q.push_back('{ir: ir7, wb: 32'h55, am: 5'd7});
        @(negedge clk);
        drive(ir8, 32'h66, 32'h0, 32'h0, 1'b0);
        e = q.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (v_out !== 1'b1 || r_out !== 1'b0 || dmem_req !== 1'b0 ||
                IR_out !== e.ir || WB_out !== e.wb || FM !== e.wb || AM !== e.am)
                begin n_fail++; $display("FAIL stall%0d: v=%b r_out=%b req=%b IR=%h WB=%h AM=%0d required 1 0 0 %h %h %0d",
                    k, v_out, r_out, dmem_req, IR_out, WB_out, AM, e.ir, e.wb, e.am); end
            dmem_ack = (k == 1);
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        r_in = 1'b1;
        q.push_back('{ir: ir8, wb: 32'h66, am: 5'd8});
        @(negedge clk); v_in = 1'b0;
        e = q.pop_front(); n_tests++;
        if (v_out !== 1'b1 || IR_out !== e.ir || WB_out !== e.wb || AM !== e.am)
            begin n_fail++; $display("FAIL stall_next: v=%b IR=%h WB=%h AM=%0d required 1 %h %h %0d",
                v_out, IR_out, WB_out, AM, e.ir, e.wb, e.am); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir;
        r_in = 1'b1;
        @(negedge clk);
        ir = mk(T_OP, 3'b000, 5'd10);
        drive(ir, 32'h111, 32'h0, 32'h0, 1'b0);
        q.push_back('{ir: ir, wb: 32'h111, am: 5'd10});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                ir = mk(T_OP, 3'b000, 5'(10 + i));
                drive(ir, 32'h111 * (i + 1), 32'h0, 32'h0, 1'b0);
                q.push_back('{ir: ir, wb: 32'h111 * (i + 1), am: 5'(10 + i)});
            end else begin
                v_in = 1'b0;
            end
            e = q.pop_front(); n_tests++;
            if (v_out !== 1'b1 || r_out !== 1'b1 || IR_out !== e.ir || WB_out !== e.wb || AM !== e.am)
                begin n_fail++; $display("FAIL b2b%0d: v=%b r_out=%b IR=%h WB=%h AM=%0d required 1 1 %h %h %0d",
                    i, v_out, r_out, IR_out, WB_out, AM, e.ir, e.wb, e.am); end
        end
    endtask

    task automatic test_rst_wait();
        @(negedge clk);
        drive(mk(T_LD, 3'b010, 5'd9), 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk); v_in = 1'b0;
        n_tests++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_req: got %b required 1", dmem_req); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_tests++;
        if (dmem_req !== 1'b0 || v_out !== 1'b0 || r_out !== 1'b1 || AM !== 5'd0)
            begin n_fail++; $display("FAIL rstw_abort: req=%b v=%b r_out=%b AM=%0d required 0 0 1 0", dmem_req, v_out, r_out, AM); end
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk); dmem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (v_out !== 1'b0 || dmem_req !== 1'b0 || WB_out !== 32'h0 || AM !== 5'd0 || r_out !== 1'b1)
                begin n_fail++; $display("FAIL rstw_late%0d: v=%b req=%b WB=%h AM=%0d r_out=%b required 0 0 0 0 1",
                    k, v_out, dmem_req, WB_out, AM, r_out); end
            @(negedge clk);
        end
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        drive(mk(T_LD, 3'b010, 5'd6), 32'h102, 32'h0, 32'h0, 1'b0);
        @(negedge clk); v_in = 1'b0;
        n_tests++;
        if (misalign !== 1'b1 || v_out !== 1'b1 || dmem_req !== 1'b0 || WB_out !== 32'h0 || AM !== 5'd0)
            begin n_fail++; $display("FAIL mis_lw: mis=%b v=%b req=%b WB=%h AM=%0d required 1 1 0 0 0",
                misalign, v_out, dmem_req, WB_out, AM); end
        @(negedge clk);
        n_tests++;
        if (misalign !== 1'b0 || v_out !== 1'b0)
            begin n_fail++; $display("FAIL mis_clear: mis=%b v=%b required 0 0", misalign, v_out); end
`else
        @(negedge clk);
        drive(mk(T_ST, 3'b010, 5'd0), 32'h102, 32'h0, 32'hCAFEF00D, 1'b0);
        @(negedge clk); v_in = 1'b0;
        n_tests++;
        if (dmem_req !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'hCAFEF00D || dmem_addr !== 32'h102)
            begin n_fail++; $display("FAIL odd_sw: req=%b be=%b wd=%h addr=%h required 1 1111 cafef00d 00000102",
                dmem_req, dmem_be, dmem_wdata, dmem_addr); end
        dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0;
        drive(mk(T_LD, 3'b001, 5'd6), 32'h103, 32'h0, 32'h0, 1'b0);
        @(negedge clk); v_in = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h9ABC1234;
        @(negedge clk); dmem_ack = 1'b0;
        n_tests++;
        if (v_out !== 1'b1 || WB_out !== 32'hFFFF9ABC || AM !== 5'd6)
            begin n_fail++; $display("FAIL odd_lh: v=%b WB=%h AM=%0d required 1 ffff9abc 6", v_out, WB_out, AM); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_stall();
        test_back_to_back();
        test_rst_wait();
        test_align();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
